// File: rtl/sdram_if_pkg.sv
// Shared types and constants for the SDRAM port responder and its bus interface.
package sdram_if_pkg;

  localparam int DEF_ADDR_WIDTH = 24;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [31:0] RANGE_ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    ACK,
    GAP,
    REFRESH
  } state_t;

endpackage

// File: rtl/sdram_port_responder_if.sv
// Single-word SDRAM req/ack bus between the MMU (master) and the responder (slave).
interface sdram_port_responder_if
  import sdram_if_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] sdram_addr;
  logic                  sdram_write;
  logic [DATA_WIDTH-1:0] sdram_write_data;
  logic                  sdram_req;
  logic [DATA_WIDTH-1:0] sdram_read_data;
  logic                  sdram_ack;

  modport master (
    output sdram_addr,
    output sdram_write,
    output sdram_write_data,
    output sdram_req,
    input  sdram_read_data,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr,
    input  sdram_write,
    input  sdram_write_data,
    input  sdram_req,
    output sdram_read_data,
    output sdram_ack
  );

endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh period counter with a non-stacking pending flag.
module sdram_refresh_timer
  import sdram_if_pkg::*;
#(
  parameter int REFRESH_PERIOD = 512
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_pending
);

  localparam int CNT_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= CNT_W'(REFRESH_PERIOD - 1);
      r_pending <= 1'b0;
    end else begin
      if (r_cnt == '0) begin
        r_cnt <= CNT_W'(REFRESH_PERIOD - 1);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
      // A second expiry while already pending just re-sets the same flag.
      if (i_clear) begin
        r_pending <= 1'b0;
      end else if (r_cnt == '0) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/sdram_port_responder.sv
// SDRAM req/ack responder backed by an internal word array, with refresh blackouts.
// Optional access/refresh statistics counters are built when SDRAM_RESP_STATS_EN is defined.
module sdram_port_responder
  import sdram_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_AW         = 10,
  parameter int READ_LAT       = 3,
  parameter int WRITE_LAT      = 2,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_port_responder_if.slave bus,
  output logic                 range_err,
  output logic                 in_refresh
`ifdef SDRAM_RESP_STATS_EN
  ,
  input  logic                 stat_clear,
  output logic [15:0]          stat_reads,
  output logic [15:0]          stat_writes,
  output logic [15:0]          stat_refreshes
`endif
);

  localparam int MAX_LAT  = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LAT_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int PAT_REPS = (DATA_WIDTH + 31) / 32;

  function automatic logic [DATA_WIDTH-1:0] oor_word();
    logic [PAT_REPS*32-1:0] rep;
    rep = {PAT_REPS{RANGE_ERR_PATTERN}};
    return rep[DATA_WIDTH-1:0];
  endfunction

  state_t                r_state;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [REF_W-1:0]      r_ref_cnt;
  logic                  r_write;
  logic                  r_oor;
  logic                  r_ack;
  logic                  r_range_err;
  logic                  r_in_refresh;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [MEM_AW-1:0]     r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

  logic w_pending;
  logic w_ref_start;
  logic w_accept;
  logic w_done;
  logic w_commit_wr;
  logic w_oor;

  assign w_oor       = |bus.sdram_addr[ADDR_WIDTH-1:MEM_AW];
  assign w_ref_start = (r_state == IDLE) && w_pending;
  assign w_accept    = (r_state == IDLE) && !w_pending && bus.sdram_req;
  assign w_done      = (r_state == BUSY) && (r_lat_cnt == '0);
  assign w_commit_wr = w_done && r_write && !r_oor;

  sdram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_refresh (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_ref_start),
    .o_pending(w_pending)
  );

  // Accept stage: address/data capture, no reset needed on pure datapath.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= bus.sdram_addr[MEM_AW-1:0];
      r_wdata <= bus.sdram_write_data;
    end
  end

  // Commit stage: the array is only touched at the final latency edge.
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_ref_cnt    <= '0;
      r_write      <= 1'b0;
      r_oor        <= 1'b0;
      r_ack        <= 1'b0;
      r_range_err  <= 1'b0;
      r_in_refresh <= 1'b0;
      r_read_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_state      <= REFRESH;
            r_in_refresh <= 1'b1;
            r_ref_cnt    <= REF_W'(REFRESH_CYCLES - 1);
          end else if (bus.sdram_req) begin
            r_state   <= BUSY;
            r_write   <= bus.sdram_write;
            r_oor     <= w_oor;
            r_lat_cnt <= bus.sdram_write ? LAT_W'(WRITE_LAT - 1) : LAT_W'(READ_LAT - 1);
            if (w_oor) begin
              r_range_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (r_lat_cnt == '0) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            if (!r_write) begin
              r_read_data <= r_oor ? oor_word() : r_mem[r_idx];
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ACK: begin
          r_ack   <= 1'b0;
          r_state <= GAP;
        end
        // One dead cycle lets the initiator drop req before IDLE samples it.
        GAP: begin
          r_state <= IDLE;
        end
        REFRESH: begin
          if (r_ref_cnt == '0) begin
            r_state      <= IDLE;
            r_in_refresh <= 1'b0;
          end else begin
            r_ref_cnt <= r_ref_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sdram_ack       = r_ack;
  assign bus.sdram_read_data = r_read_data;
  assign range_err           = r_range_err;
  assign in_refresh          = r_in_refresh;

`ifdef SDRAM_RESP_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_stat_reads;
  logic [15:0] r_stat_writes;
  logic [15:0] r_stat_refreshes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_reads     <= '0;
      r_stat_writes    <= '0;
      r_stat_refreshes <= '0;
    end else if (stat_clear) begin
      r_stat_reads     <= '0;
      r_stat_writes    <= '0;
      r_stat_refreshes <= '0;
    end else begin
      if (w_done && !r_write) begin
        r_stat_reads <= sat_inc(r_stat_reads);
      end
      if (w_done && r_write) begin
        r_stat_writes <= sat_inc(r_stat_writes);
      end
      if (w_ref_start) begin
        r_stat_refreshes <= sat_inc(r_stat_refreshes);
      end
    end
  end

  assign stat_reads     = r_stat_reads;
  assign stat_writes    = r_stat_writes;
  assign stat_refreshes = r_stat_refreshes;
`endif

endmodule

// File: tb/tb_sdram_port_responder.sv
// Scoreboard bench for sdram_port_responder: directed accesses, refresh collision, range errors, reset abort.
module tb_sdram_port_responder;
  import sdram_if_pkg::*;

  localparam int RLAT = 3;
  localparam int WLAT = 2;
  localparam int RP   = 512;
  localparam int RC   = 8;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        range_err;
  logic        in_refresh;
  int unsigned cyc = 0;
  int unsigned rel = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        sb[$];

`ifdef SDRAM_RESP_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
  logic [15:0] stat_refreshes;
`endif

  sdram_port_responder_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) bus ();

  sdram_port_responder #(
    .ADDR_WIDTH    (24),
    .DATA_WIDTH    (32),
    .MEM_AW        (10),
    .READ_LAT      (RLAT),
    .WRITE_LAT     (WLAT),
    .REFRESH_PERIOD(RP),
    .REFRESH_CYCLES(RC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .range_err (range_err),
    .in_refresh(in_refresh)
`ifdef SDRAM_RESP_STATS_EN
    ,
    .stat_clear    (stat_clear),
    .stat_reads    (stat_reads),
    .stat_writes   (stat_writes),
    .stat_refreshes(stat_refreshes)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every ack pops one expectation and checks timing and read data.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sdram_ack === 1'b1) begin
        check("ack_single_cycle", {63'd0, prev}, 64'd0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: ack at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", 64'(cyc), 64'(e.cyc));
          if (!e.wr) check("read_data", 64'(bus.sdram_read_data), 64'(e.data));
        end
      end
      prev = bus.sdram_ack;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_acks(input int n);
    int seen = 0;
    for (int k = 0; k < 200 && seen < n; k++) begin
      @(negedge clk);
      if (bus.sdram_ack === 1'b1) seen++;
    end
    check("ack_count", 64'(seen), 64'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    bus.sdram_req = 1'b0;
    #1;
    check("rst_ack", 64'(bus.sdram_ack), 64'd0);
    check("rst_read_data", 64'(bus.sdram_read_data), 64'd0);
    check("rst_range_err", 64'(range_err), 64'd0);
    check("rst_in_refresh", 64'(in_refresh), 64'd0);
`ifdef SDRAM_RESP_STATS_EN
    check("rst_stats", {16'd0, stat_reads, stat_writes, stat_refreshes}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rel     = cyc;
  endtask

  task automatic drive(input bit wr, input logic [23:0] a, input logic [31:0] d);
    bus.sdram_addr       = a;
    bus.sdram_write      = wr;
    bus.sdram_write_data = d;
    bus.sdram_req        = 1'b1;
  endtask

  task automatic access(input bit wr, input logic [23:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    drive(wr, a, d);
    sb.push_back('{wr, exp_rd, cyc + 1 + (wr ? WLAT : RLAT)});
    wait_acks(1);
    bus.sdram_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int hi;
    int unsigned c;
    reset_n              = 1'b0;
    bus.sdram_req        = 1'b0;
    bus.sdram_write      = 1'b0;
    bus.sdram_addr       = '0;
    bus.sdram_write_data = '0;
`ifdef SDRAM_RESP_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Write/read round trip with per-direction latency.
    do_reset();
    access(1'b1, 24'h000010, 32'h1234_5678, 32'h0);
    access(1'b0, 24'h000010, 32'h0, 32'h1234_5678);
    access(1'b1, 24'h000020, 32'hCAFE_0020, 32'h0);
    access(1'b0, 24'h000020, 32'h0, 32'hCAFE_0020);

    // Req held high across four reads: one accept every READ_LAT+3 cycles.
    do_reset();
    @(negedge clk);
    drive(1'b0, 24'h000010, 32'h0);
    c = cyc;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 32'h1234_5678, c + 1 + RLAT + 6 * i});
    wait_acks(4);
    bus.sdram_req = 1'b0;
    repeat (8) @(negedge clk);

    // Out-of-range accesses.
    do_reset();
    access(1'b1, 24'h000000, 32'hA5A5_5A5A, 32'h0);
    check("range_err_clear", 64'(range_err), 64'd0);
    access(1'b0, 24'h000400, 32'h0, 32'hDEAD_BEEF);
    check("range_err_set", 64'(range_err), 64'd1);
    access(1'b1, 24'h000400, 32'hFFFF_FFFF, 32'h0);
    access(1'b0, 24'h000000, 32'h0, 32'hA5A5_5A5A);
    check("range_err_sticky", 64'(range_err), 64'd1);

    // Reset asserted mid-write: write lost, outputs cleared asynchronously.
    do_reset();
    access(1'b0, 24'h800000, 32'h0, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, 24'h000020, 32'h1111_2222);
    @(negedge clk);
    reset_n       = 1'b0;
    bus.sdram_req = 1'b0;
    #1;
    check("abort_ack", 64'(bus.sdram_ack), 64'd0);
    check("abort_read_data", 64'(bus.sdram_read_data), 64'd0);
    check("abort_range_err", 64'(range_err), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    access(1'b0, 24'h000020, 32'h0, 32'hCAFE_0020);

    // Request arrives in the cycle refresh becomes pending: refresh wins.
    do_reset();
    while (cyc != rel + RP) @(negedge clk);
    check("in_refresh_before", 64'(in_refresh), 64'd0);
    drive(1'b0, 24'h000010, 32'h0);
    sb.push_back('{1'b0, 32'h1234_5678, cyc + RC + 5});
    hi = 0;
    for (int k = 0; k < RC + 4; k++) begin
      @(negedge clk);
      if (in_refresh) hi++;
    end
    check("refresh_length", 64'(hi), 64'(RC));
    wait_acks(1);
    bus.sdram_req = 1'b0;
    repeat (2) @(negedge clk);
    check("in_refresh_after", 64'(in_refresh), 64'd0);

`ifdef SDRAM_RESP_STATS_EN
    do_reset();
    access(1'b1, 24'h000030, 32'h0000_0030, 32'h0);
    access(1'b1, 24'h000031, 32'h0000_0031, 32'h0);
    access(1'b1, 24'h000032, 32'h0000_0032, 32'h0);
    access(1'b0, 24'h000030, 32'h0, 32'h0000_0030);
    access(1'b0, 24'h000031, 32'h0, 32'h0000_0031);
    for (int k = 0; k < 600 && !in_refresh; k++) @(negedge clk);
    check("stat_refresh_seen", 64'(in_refresh), 64'd1);
    check("stat_writes", 64'(stat_writes), 64'd3);
    check("stat_reads", 64'(stat_reads), 64'd2);
    check("stat_refreshes", 64'(stat_refreshes), 64'd1);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    check("stat_cleared", {16'd0, stat_reads, stat_writes, stat_refreshes}, 64'd0);
    repeat (12) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_responder.md
Name: sdram_port_responder

Overview:
- Responder end of the core's SDRAM req/ack port. The Memory_Management_Unit is the initiator; this block sits opposite it.
- Accepts one single-word access per request, executes it against an internal word array after a programmable latency, and returns a one-cycle ack.
- Models periodic refresh blackouts, so the initiator's stall handling is exercised. Used as the bench/on-chip SDRAM stand-in.

Parameters:
- ADDR_WIDTH, 24, width of sdram_addr (matches SDRAM_ADDR_WIDTH).
- DATA_WIDTH, 32, width of the data buses (matches SDRAM_DATA_WIDTH).
- MEM_AW, 10, log2 of internal array depth; index = sdram_addr[MEM_AW-1:0].
- READ_LAT, 3, cycles from accept to ack for reads (>=1).
- WRITE_LAT, 2, cycles from accept to ack for writes (>=1).
- REFRESH_PERIOD, 512, cycles between refresh requests (>=REFRESH_CYCLES+4).
- REFRESH_CYCLES, 8, length of a refresh blackout.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- sdram_addr  in  ADDR_WIDTH  word address from the initiator.
- sdram_write  in  1  1=write, 0=read; sampled at accept.
- sdram_write_data  in  DATA_WIDTH  write data; sampled at accept.
- sdram_req  in  1  request level; held by the initiator until ack.
- sdram_read_data  out  DATA_WIDTH  read data; valid from the ack cycle until the next ack.
- sdram_ack  out  1  one-cycle completion pulse.
- range_err  out  1  sticky: an access had nonzero sdram_addr[ADDR_WIDTH-1:MEM_AW].
- in_refresh  out  1  high while a refresh blackout is in progress.

Behaviour:
- Reset (reset_n low, async): state=IDLE; sdram_ack=0; sdram_read_data=0; range_err=0; in_refresh=0; refresh counter=REFRESH_PERIOD-1; refresh_pending=0. Array contents are not reset.
- Refresh counter: decrements every cycle in every state. On reaching 0 it reloads REFRESH_PERIOD-1 and sets refresh_pending. A second expiry while pending does not stack; only one refresh runs.
- FSM states: IDLE, BUSY, ACK, GAP, REFRESH.
- IDLE:
  - If refresh_pending, go to REFRESH; refresh has priority over a simultaneous req.
  - Else if sdram_req, accept: latch addr/write/data, load the latency counter with READ_LAT-1 or WRITE_LAT-1, go to BUSY.
- BUSY: decrement the latency counter. At 0, on the same edge:
  - Writes commit to the array; reads register array data into sdram_read_data.
  - Drive sdram_ack=1 and go to ACK.
  - Ack rises exactly LAT edges after the accept edge.
- ACK: sdram_ack high for this cycle only; next state GAP.
- GAP: sdram_req is ignored for one cycle so the initiator can deassert; then IDLE. Minimum request-to-request spacing is LAT+3 cycles.
- REFRESH: in_refresh=1; clear refresh_pending on entry; stay REFRESH_CYCLES cycles; then IDLE. A req arriving here waits and is serviced afterwards.
- Refresh falling due during BUSY/ACK/GAP is deferred until IDLE; an in-flight access is never aborted.
- Out-of-range address:
  - range_err is set; the access still completes with ack.
  - Writes are dropped.
  - Reads return {DATA_WIDTH/32{32'hDEAD_BEEF}} truncated to DATA_WIDTH.
- Deassertion of sdram_req mid-access is ignored; the access completes and acks.
- reset_n assertion mid-access aborts it. A write not yet committed is lost; ack never appears.
- Write followed by a read of the same address returns the new data.

Optional Feature:
- Macro: SDRAM_RESP_STATS_EN.
- Defined:
  - Adds outputs stat_reads[15:0], stat_writes[15:0], stat_refreshes[15:0].
  - Each is incremented at its ack edge or refresh entry, saturates at 16'hFFFF, and resets to 0.
  - Adds input stat_clear (synchronous, clears all three; a clear wins over a same-cycle increment).
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package sdram_if_pkg:
  - state enum {IDLE,BUSY,ACK,GAP,REFRESH};
  - RANGE_ERR_PATTERN=32'hDEAD_BEEF;
  - default width constants (24/32).
- One natural sub-module, sdram_refresh_timer: the period counter plus the pending flag, with a clear input.

Test Plan:
- Write 0x1234_5678 to addr 0x10, then read 0x10 (READ_LAT=3) -> ack 2 edges after the write accept and 3 edges after the read accept; read_data=0x1234_5678.
- Hold req high continuously for 4 reads -> exactly 4 ack pulses, each 1 cycle; accept spacing READ_LAT+3=6 cycles.
- Req arrives the same cycle refresh_pending sets in IDLE (REFRESH_PERIOD=16, REFRESH_CYCLES=8) -> in_refresh high 8 cycles; accept on the following IDLE cycle; ack 3 edges later.
- Read addr 0x00_0400 with MEM_AW=10 -> ack, read_data=0xDEAD_BEEF, range_err=1 and sticky; array addr 0 unchanged.
- Assert reset_n low during BUSY of a write to 0x20 -> outputs zero asynchronously; no ack; later read of 0x20 returns its old value.
- SDRAM_RESP_STATS_EN: 3 writes, 2 reads, 1 refresh -> stat_writes=3, stat_reads=2, stat_refreshes=1; stat_clear -> all 0 next cycle.
